keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 190 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, samples the
// synchronized rows on a divided strobe, debounces press and release, and reports hex codes.
module keypad_scanner #(
   parameter int SCAN_DIV     = 16,
   parameter int DEBOUNCE_CNT = 4
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_down
);

   localparam logic [1:0]  ST_SCAN     = 2'd0;
   localparam logic [1:0]  ST_DEBOUNCE = 2'd1;
   localparam logic [1:0]  ST_PRESSED  = 2'd2;
   localparam logic [1:0]  ST_RELEASE  = 2'd3;
   localparam logic [15:0] DIV_LAST    = 16'(SCAN_DIV - 1);
   localparam logic [7:0]  DB_LAST     = 8'(DEBOUNCE_CNT);
   localparam logic        DB_SINGLE   = (DEBOUNCE_CNT == 1);

   logic [3:0]  sync1_q, sync1_d, rs_q, rs_d;
   logic [15:0] div_q, div_d;
   logic [1:0]  state_q, state_d;
   logic [3:0]  col_q, col_d, pat_q, pat_d, key_code_q, key_code_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        key_valid_q, key_valid_d, key_down_q, key_down_d;
   logic        strobe_s;
   logic [7:0]  cnt_inc_s;

   function automatic logic one_low(input logic [3:0] v);
      case (v)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
         default:                            one_low = 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] low_index(input logic [3:0] v);
      case (v)
         4'b1110: low_index = 2'd0;
         4'b1101: low_index = 2'd1;
         4'b1011: low_index = 2'd2;
         4'b0111: low_index = 2'd3;
         default: low_index = 2'd0;
      endcase
   endfunction

   // Rows top to bottom: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D, with * = E and # = F.
   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
         4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
         4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
         4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;  4'hE: key_map = 4'hF;  4'hF: key_map = 4'hD;
         default: key_map = 4'h0;
      endcase
   endfunction

   function automatic logic [3:0] rotate(input logic [3:0] c);
      rotate = {c[2:0], c[3]};
   endfunction

   assign strobe_s  = (div_q == DIV_LAST);
   assign cnt_inc_s = cnt_q + 8'd1;

   // Next-state logic: synchronizer, scan divider and the press/release debounce FSM.
   always_comb begin
      sync1_d     = row;
      rs_d        = sync1_q;
      div_d       = strobe_s ? 16'd0 : div_q + 16'd1;
      state_d     = state_q;
      col_d       = col_q;
      pat_d       = pat_q;
      cnt_d       = cnt_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_down_d  = key_down_q;
      if (strobe_s) begin
         case (state_q)
            ST_SCAN: begin
               if (one_low(rs_q)) begin
                  pat_d = rs_q;
                  if (DB_SINGLE) begin
                     state_d     = ST_PRESSED;
                     key_code_d  = key_map(low_index(rs_q), low_index(col_q));
                     key_valid_d = 1'b1;
                     key_down_d  = 1'b1;
                     cnt_d       = 8'd0;
                  end else begin
                     state_d = ST_DEBOUNCE;
                     cnt_d   = 8'd1;
                  end
               end else begin
                  col_d = rotate(col_q);
               end
            end
            ST_DEBOUNCE: begin
               if (rs_q == pat_q) begin
                  if (cnt_inc_s == DB_LAST) begin
                     state_d     = ST_PRESSED;
                     key_code_d  = key_map(low_index(pat_q), low_index(col_q));
                     key_valid_d = 1'b1;
                     key_down_d  = 1'b1;
                     cnt_d       = 8'd0;
                  end else begin
                     cnt_d = cnt_inc_s;
                  end
               end else begin
                  state_d = ST_SCAN;
                  cnt_d   = 8'd0;
                  col_d   = rotate(col_q);
               end
            end
            ST_PRESSED: begin
               if (rs_q == 4'b1111) begin
                  if (DB_SINGLE) begin
                     state_d    = ST_SCAN;
                     key_down_d = 1'b0;
                     col_d      = rotate(col_q);
                     cnt_d      = 8'd0;
                  end else begin
                     state_d = ST_RELEASE;
                     cnt_d   = 8'd1;
                  end
               end else begin
                  state_d = ST_PRESSED;
               end
            end
            ST_RELEASE: begin
               if (rs_q == 4'b1111) begin
                  if (cnt_inc_s == DB_LAST) begin
                     state_d    = ST_SCAN;
                     key_down_d = 1'b0;
                     col_d      = rotate(col_q);
                     cnt_d      = 8'd0;
                  end else begin
                     cnt_d = cnt_inc_s;
                  end
               end else begin
                  // A bounce during release falls back to the held key, never a new press.
                  state_d = ST_PRESSED;
                  cnt_d   = 8'd0;
               end
            end
            default: begin
               state_d = ST_SCAN;
               col_d   = 4'b1110;
               cnt_d   = 8'd0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State registers with synchronous clear taking priority over any strobe.
   always_ff @(posedge clk) begin
      if (clr) begin
         sync1_q     <= 4'b1111;
         rs_q        <= 4'b1111;
         div_q       <= 16'd0;
         state_q     <= ST_SCAN;
         col_q       <= 4'b1110;
         pat_q       <= 4'b1111;
         cnt_q       <= 8'd0;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         key_down_q  <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         rs_q        <= rs_d;
         div_q       <= div_d;
         state_q     <= state_d;
         col_q       <= col_d;
         pat_q       <= pat_d;
         cnt_q       <= cnt_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_down_q  <= key_down_d;
      end
   end

   assign col       = col_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives rows from the column drive; expected
// codes are queued on each press and compared when key_valid pulses.
module tb_keypad_scanner;

   logic        clk = 1'b0;
   logic        clr;
   logic [3:0]  row, col, key_code;
   logic        key_valid, key_down;
   logic [15:0] keys;
   logic        mon_en = 1'b0;
   logic [3:0]  exp_q[$];
   int          total = 0;
   int          bad   = 0;

   typedef struct {
      logic [1:0] r;
      logic [1:0] c;
      logic [3:0] code;
   } vec_t;
   vec_t vecs[16];

   always #5 clk = ~clk;

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
      .clk(clk), .clr(clr), .row(row), .col(col),
      .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
   );

   // Physical keypad: a pressed key shorts its row to its column when that column is driven low.
   always_comb begin
      row = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && col[c] === 1'b0) row[r] = 1'b0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [3:0] e;
      if (mon_en) begin
         check("col_one_low", {31'd0, (col == 4'b1110 || col == 4'b1101 ||
                                       col == 4'b1011 || col == 4'b0111)}, 32'd1);
         if (key_valid && !clr) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("key_code", {28'd0, key_code}, {28'd0, e});
               check("down_at_valid", {31'd0, key_down}, 32'd1);
            end
         end
      end
   end

   task automatic do_reset();
      clr = 1'b1;
      repeat (2) @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic wait_down(input logic lvl, input string name, input int budget);
      int n = 0;
      while (key_down !== lvl && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'd0, key_down}, {31'd0, lvl});
   endtask

   task automatic hold_then_release(input string name);
      logic [3:0] held;
      held = col;
      repeat (12) @(negedge clk);
      check({name, "_col_held"}, {28'd0, col}, {28'd0, held});
      check({name, "_still_down"}, {31'd0, key_down}, 32'd1);
      keys = 16'd0;
      repeat (6) @(negedge clk);
      check({name, "_down_after_rel"}, {31'd0, key_down}, 32'd1);
      wait_down(1'b0, {name, "_released"}, 40);
      check({name, "_queue_drained"}, exp_q.size(), 32'd0);
   endtask

   task automatic press_release(input logic [1:0] r, input logic [1:0] c, input logic [3:0] code);
      string nm;
      nm = $sformatf("key_r%0d_c%0d", r, c);
      keys = 16'd0;
      keys[{r, c}] = 1'b1;
      exp_q.push_back(code);
      wait_down(1'b1, {nm, "_accepted"}, 200);
      hold_then_release(nm);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] idle_seq[4];
      logic [3:0] seen;
      idle_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      vecs = '{
         '{2'd1, 2'd2, 4'h6}, '{2'd0, 2'd0, 4'h1}, '{2'd0, 2'd1, 4'h2}, '{2'd0, 2'd3, 4'hA},
         '{2'd1, 2'd0, 4'h4}, '{2'd1, 2'd3, 4'hB}, '{2'd2, 2'd0, 4'h7}, '{2'd2, 2'd1, 4'h8},
         '{2'd2, 2'd2, 4'h9}, '{2'd2, 2'd3, 4'hC}, '{2'd3, 2'd0, 4'hE}, '{2'd3, 2'd1, 4'h0},
         '{2'd3, 2'd2, 4'hF}, '{2'd3, 2'd3, 4'hD}, '{2'd0, 2'd2, 4'h3}, '{2'd1, 2'd1, 4'h5}
      };
      keys = 16'd0;
      @(negedge clk);
      do_reset();
      mon_en = 1'b1;
      check("rst_col", {28'd0, col}, 32'h0000000E);
      check("rst_code", {28'd0, key_code}, 32'd0);
      check("rst_valid", {31'd0, key_valid}, 32'd0);
      check("rst_down", {31'd0, key_down}, 32'd0);

      // Idle rotation, one column step every 4 clocks.
      for (int i = 0; i < 16; i++) begin
         check($sformatf("idle_col_%0d", i), {28'd0, col}, {28'd0, idle_seq[i % 4]});
         repeat (4) @(negedge clk);
      end
      check("idle_code", {28'd0, key_code}, 32'd0);

      for (int i = 0; i < 16; i++) press_release(vecs[i].r, vecs[i].c, vecs[i].code);

      // Bouncing "0" key, period 6 against a 4-clock strobe.
      exp_q.push_back(4'h0);
      for (int i = 0; i < 7; i++) begin
         keys[13] = (i % 2 == 0);
         repeat (3) @(negedge clk);
      end
      check("bounce_no_pulse", exp_q.size(), 32'd1);
      check("bounce_not_down", {31'd0, key_down}, 32'd0);
      keys[13] = 1'b1;
      wait_down(1'b1, "bounce_accepted", 200);
      hold_then_release("bounce");

      // Two keys on column 0: ignored until one is released.
      keys = 16'd0;
      keys[0] = 1'b1;
      keys[8] = 1'b1;
      seen = 4'd0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         seen = seen | ~col;
      end
      check("multi_rotates", {28'd0, seen}, 32'h0000000F);
      check("multi_not_down", {31'd0, key_down}, 32'd0);
      check("multi_no_pulse", exp_q.size(), 32'd0);
      keys[8] = 1'b0;
      exp_q.push_back(4'h1);
      wait_down(1'b1, "multi_accepted", 200);
      hold_then_release("multi");

      // Release bounce on "#".
      keys = 16'd0;
      keys[14] = 1'b1;
      exp_q.push_back(4'hF);
      wait_down(1'b1, "hash_accepted", 200);
      repeat (4) @(negedge clk);
      keys = 16'd0;
      repeat (4) @(negedge clk);
      keys[14] = 1'b1;
      repeat (4) @(negedge clk);
      check("relbounce_down", {31'd0, key_down}, 32'd1);
      hold_then_release("relbounce");

      // Clear while "D" is debouncing, then fresh detection with the key still held.
      do_reset();
      keys = 16'd0;
      keys[15] = 1'b1;
      repeat (18) @(negedge clk);
      check("midpress_col_held", {28'd0, col}, 32'h00000007);
      check("midpress_not_down", {31'd0, key_down}, 32'd0);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("clr_col", {28'd0, col}, 32'h0000000E);
      check("clr_code", {28'd0, key_code}, 32'd0);
      check("clr_valid", {31'd0, key_valid}, 32'd0);
      check("clr_down", {31'd0, key_down}, 32'd0);
      exp_q.push_back(4'hD);
      wait_down(1'b1, "d_reaccepted", 200);
      hold_then_release("d_after_clr");

      repeat (4) @(negedge clk);
      check("final_queue", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
